dynamic_budget_tracker: RTL and testbench
=========================================

DYNAMIC_BUDGET_TRACKER -- requirements
Module: dynamic_budget_tracker

Interface
REQ-001 SHALL have parameter NumCh, default 2, number of independent channels (e.g. read, write).
REQ-002 SHALL have parameter MaxTxns, default 8, maximum outstanding transactions per channel.
REQ-003 SHALL have parameter LenWidth, default 8, width of the AXI burst len field.
REQ-004 SHALL have parameter CntWidth, default 16, width of the budget accumulator and timer.
REQ-005 SHALL have parameter Overhead, default 5, fixed per-transaction cycle overhead added to len.
REQ-006 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous clear of all state.
- alloc_i  in  NumCh  transaction issued on channel.
- alloc_len_i  in  NumCh x LenWidth  len of the issued transaction.
- retire_i  in  NumCh  transaction completed on channel.
- retire_len_i  in  NumCh x LenWidth  len of the completed transaction.
- progress_i  in  NumCh  handshake progress seen (beat/response); reloads the timer.
- accum_o  out  NumCh x CntWidth  accumulated budget of outstanding transactions.
- outstanding_o  out  NumCh x $clog2(MaxTxns+1)  outstanding transaction count.
- budget_left_o  out  NumCh x CntWidth  remaining timer value.
- timeout_o  out  NumCh  sticky timeout flag.
- err_overflow_o  out  NumCh  sticky: alloc while full, or accumulator saturated.
- err_underflow_o  out  NumCh  sticky: retire while empty, or accumulator clamped at 0.

Function
REQ-007 SHALL process channels independently and identically; all outputs registered, updating one cycle after the sampled event.
REQ-008 SHALL compute the per-transaction cost as len + Overhead, zero-extended to CntWidth.
REQ-009 SHALL update accum as accum + alloc cost - retire cost in the same cycle when both are accepted.
REQ-010 SHALL saturate accum at 2^CntWidth-1 on overflow and set err_overflow_o; SHALL clamp to 0 on underflow and set err_underflow_o.
REQ-011 SHALL accept alloc only when outstanding < MaxTxns, or when outstanding == MaxTxns with a simultaneous accepted retire; otherwise ignore it and set err_overflow_o.
REQ-012 SHALL accept retire only when outstanding > 0, judged on the current-cycle count; otherwise ignore it and set err_underflow_o, while a simultaneous alloc is still accepted.
REQ-013 SHALL run a per-channel FSM with states IDLE, COUNT, TIMEOUT.
REQ-014 IDLE: budget_left = 0; SHALL move to COUNT when next outstanding > 0, loading budget_left with the next accum.
REQ-015 COUNT: SHALL decrement budget_left by 1 per cycle.
REQ-016 COUNT: SHALL reload budget_left with the next accum on any accepted alloc, accepted retire or progress_i; reload has priority over decrement.
REQ-017 COUNT: SHALL move to IDLE when next outstanding == 0, which has priority over timeout.
REQ-018 COUNT: SHALL move to TIMEOUT when budget_left == 0, no reload occurs this cycle, and outstanding stays > 0.
REQ-019 TIMEOUT: SHALL assert timeout_o and hold budget_left at 0.
REQ-020 TIMEOUT: SHALL keep tracking accum and outstanding, and SHALL remain in TIMEOUT until clear_i or reset.
REQ-021 Error flags and timeout_o SHALL be sticky until clear_i or reset.
REQ-022 clear_i SHALL return every register to its reset value on the next edge, overriding same-cycle alloc/retire/progress.

Reset
REQ-023 On rst_ni low, SHALL immediately force all outputs to 0 and all FSMs to IDLE, independent of clk_i, including mid-transaction.
REQ-024 SHALL ignore all inputs while rst_ni is low; the first event is sampled on the first rising edge after release.

Verification
REQ-025 Alloc len=3 on ch0 at cycle 0 -> cycle 1: accum_o=8, outstanding_o=1, budget_left_o=8, state COUNT.
REQ-026 Same alloc, no progress for 8 cycles -> budget_left_o counts 7..0, then timeout_o[0]=1; clear_i -> all ch0 outputs return to 0.
REQ-027 Alloc len=3 then retire len=3 with no progress -> accum_o=0, outstanding_o=0, state IDLE, timeout_o=0.
REQ-028 With MaxTxns=8, 8 allocs len=0, then alloc+retire (len 0) in the same cycle -> outstanding_o stays 8, no error; a lone 9th alloc -> err_overflow_o=1, count stays 8.
REQ-029 Retire on an empty channel -> err_underflow_o=1, accum_o=0; with CntWidth=8, alloc len=255 -> accum_o=255 and err_overflow_o=1.
REQ-030 Assert rst_ni low mid-COUNT between clock edges -> all outputs 0 asynchronously; after release, ch1 traffic is unaffected by ch0 history.

Source files
------------

// File: rtl/dynamic_budget_tracker_if.sv
// Bundle of per-channel transaction events and budget/status results for
// dynamic_budget_tracker. The tracker connects as slave, the traffic side as master.
interface dynamic_budget_tracker_if #(
  parameter int unsigned NumCh    = 2,
  parameter int unsigned MaxTxns  = 8,
  parameter int unsigned LenWidth = 8,
  parameter int unsigned CntWidth = 16
);
  localparam int unsigned OutW = $clog2(MaxTxns + 1);

  logic                               clear_i;
  logic [NumCh-1:0]                   alloc_i;
  logic [NumCh-1:0][LenWidth-1:0]     alloc_len_i;
  logic [NumCh-1:0]                   retire_i;
  logic [NumCh-1:0][LenWidth-1:0]     retire_len_i;
  logic [NumCh-1:0]                   progress_i;
  logic [NumCh-1:0][CntWidth-1:0]     accum_o;
  logic [NumCh-1:0][OutW-1:0]         outstanding_o;
  logic [NumCh-1:0][CntWidth-1:0]     budget_left_o;
  logic [NumCh-1:0]                   timeout_o;
  logic [NumCh-1:0]                   err_overflow_o;
  logic [NumCh-1:0]                   err_underflow_o;

  modport master (
    output clear_i, alloc_i, alloc_len_i, retire_i, retire_len_i, progress_i,
    input  accum_o, outstanding_o, budget_left_o, timeout_o, err_overflow_o, err_underflow_o
  );

  modport slave (
    input  clear_i, alloc_i, alloc_len_i, retire_i, retire_len_i, progress_i,
    output accum_o, outstanding_o, budget_left_o, timeout_o, err_overflow_o, err_underflow_o
  );
endinterface

// File: rtl/dynamic_budget_tracker.sv
// Per-channel outstanding-transaction budget tracker: accumulates len+Overhead
// cost of in-flight transactions and runs a watchdog timer that flags stalls.
module dynamic_budget_tracker #(
  parameter int unsigned NumCh    = 2,
  parameter int unsigned MaxTxns  = 8,
  parameter int unsigned LenWidth = 8,
  parameter int unsigned CntWidth = 16,
  parameter int unsigned Overhead = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  dynamic_budget_tracker_if.slave        bus
);
  localparam int unsigned OutW = $clog2(MaxTxns + 1);
  // Wide enough that accum + one cost never wraps, so saturation is exact.
  localparam int unsigned SumW = CntWidth + LenWidth + 2;
  localparam logic [SumW-1:0] AccMax = (SumW'(1) << CntWidth) - SumW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [CntWidth-1:0] accum_q, accum_d;
    logic [CntWidth-1:0] budget_q, budget_d;
    logic [OutW-1:0]     out_q, out_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                alloc_acc, retire_acc, reload;
    logic [SumW-1:0]     up, down, diff;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
      retire_acc = bus.retire_i[c] && (out_q != '0);
      alloc_acc  = bus.alloc_i[c] &&
                   ((out_q < OutW'(MaxTxns)) || ((out_q == OutW'(MaxTxns)) && retire_acc));

      up    = SumW'(accum_q) +
              (alloc_acc ? SumW'(bus.alloc_len_i[c]) + SumW'(Overhead) : '0);
      down  = retire_acc ? SumW'(bus.retire_len_i[c]) + SumW'(Overhead) : '0;
      diff  = up - down;

      ovf_d   = ovf_q | (bus.alloc_i[c] && !alloc_acc);
      udf_d   = udf_q | (bus.retire_i[c] && !retire_acc);
      accum_d = diff[CntWidth-1:0];
      if (down > up) begin
        accum_d = '0;
        udf_d   = 1'b1;
      end else if (diff > AccMax) begin
        accum_d = '1;
        ovf_d   = 1'b1;
      end

      out_d  = out_q + OutW'(alloc_acc) - OutW'(retire_acc);
      reload = alloc_acc || retire_acc || bus.progress_i[c];

      state_d  = state_q;
      budget_d = budget_q;
      unique case (state_q)
        IDLE: begin
          budget_d = '0;
          if (out_d != '0) begin
            state_d  = COUNT;
            budget_d = accum_d;
          end
        end
        COUNT: begin
          // Draining to empty wins over an expiring timer.
          if (out_d == '0) begin
            state_d  = IDLE;
            budget_d = '0;
          end else if (reload) begin
            budget_d = accum_d;
          end else if (budget_q == '0) begin
            state_d  = TIMEOUT;
          end else begin
            budget_d = budget_q - CntWidth'(1);
          end
        end
        TIMEOUT: budget_d = '0;
        default: begin
          state_d  = IDLE;
          budget_d = '0;
        end
      endcase
    end

    // NOTE: async reset and sync clear both return every register to zero/IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q  <= IDLE;
        accum_q  <= '0;
        budget_q <= '0;
        out_q    <= '0;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
      end else if (bus.clear_i) begin
        state_q  <= IDLE;
        accum_q  <= '0;
        budget_q <= '0;
        out_q    <= '0;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        accum_q  <= accum_d;
        budget_q <= budget_d;
        out_q    <= out_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
      end
    end

    assign bus.accum_o[c]         = accum_q;
    assign bus.outstanding_o[c]   = out_q;
    assign bus.budget_left_o[c]   = budget_q;
    assign bus.timeout_o[c]       = (state_q == TIMEOUT);
    assign bus.err_overflow_o[c]  = ovf_q;
    assign bus.err_underflow_o[c] = udf_q;
  end

endmodule

// File: tb/tb_dynamic_budget_tracker.sv
// Directed self-checking bench for dynamic_budget_tracker: a default-parameter
// instance plus a CntWidth=8 instance for accumulator saturation.
module tb_dynamic_budget_tracker;
  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  dynamic_budget_tracker_if #(.NumCh(2), .MaxTxns(8), .LenWidth(8), .CntWidth(16)) b ();
  dynamic_budget_tracker_if #(.NumCh(2), .MaxTxns(8), .LenWidth(8), .CntWidth(8))  b8 ();

  dynamic_budget_tracker #(
    .NumCh(2), .MaxTxns(8), .LenWidth(8), .CntWidth(16), .Overhead(5)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (b.slave)
  );

  dynamic_budget_tracker #(
    .NumCh(2), .MaxTxns(8), .LenWidth(8), .CntWidth(8), .Overhead(5)
  ) dut8 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (b8.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    b.clear_i       = 1'b0;
    b.alloc_i       = '0;
    b.alloc_len_i   = '0;
    b.retire_i      = '0;
    b.retire_len_i  = '0;
    b.progress_i    = '0;
    b8.clear_i      = 1'b0;
    b8.alloc_i      = '0;
    b8.alloc_len_i  = '0;
    b8.retire_i     = '0;
    b8.retire_len_i = '0;
    b8.progress_i   = '0;
  endtask

  // One clock edge, then release all strobes; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic do_clear();
    b.clear_i  = 1'b1;
    b8.clear_i = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_ni = 1'b0;

    // Reset state
    #12;
    check("rst_accum0", b.accum_o[0], 0);
    check("rst_out0", b.outstanding_o[0], 0);
    check("rst_budget1", b.budget_left_o[1], 0);
    check("rst_timeout", b.timeout_o, 0);
    #10 rst_ni = 1'b1;

    // Alloc len=3 -> cost 8, timer loaded
    b.alloc_i[0] = 1'b1; b.alloc_len_i[0] = 8'd3;
    tick();
    check("alloc_accum", b.accum_o[0], 8);
    check("alloc_out", b.outstanding_o[0], 1);
    check("alloc_budget", b.budget_left_o[0], 8);
    check("alloc_ch1_quiet", b.outstanding_o[1], 0);

    // No progress: timer counts 7..0, then times out
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("count_%0d", i), b.budget_left_o[0], 32'(7 - i));
      check($sformatf("count_to_%0d", i), b.timeout_o[0], 0);
    end
    tick();
    check("timeout_set", b.timeout_o[0], 1);
    check("timeout_budget", b.budget_left_o[0], 0);
    check("timeout_accum", b.accum_o[0], 8);
    tick();
    check("timeout_sticky", b.timeout_o[0], 1);
    do_clear();
    check("clr_accum", b.accum_o[0], 0);
    check("clr_out", b.outstanding_o[0], 0);
    check("clr_timeout", b.timeout_o[0], 0);
    check("clr_budget", b.budget_left_o[0], 0);

    // Alloc then retire returns to IDLE without a timeout
    b.alloc_i[0] = 1'b1; b.alloc_len_i[0] = 8'd3;
    tick();
    b.retire_i[0] = 1'b1; b.retire_len_i[0] = 8'd3;
    tick();
    check("ret_accum", b.accum_o[0], 0);
    check("ret_out", b.outstanding_o[0], 0);
    check("ret_budget", b.budget_left_o[0], 0);
    tick(); tick();
    check("ret_no_timeout", b.timeout_o[0], 0);

    // Progress reloads; simultaneous alloc+retire nets the cost
    b.alloc_i[0] = 1'b1; b.alloc_len_i[0] = 8'd2;
    tick();
    tick(); tick();
    check("prog_pre", b.budget_left_o[0], 5);
    b.progress_i[0] = 1'b1;
    tick();
    check("prog_reload", b.budget_left_o[0], 7);
    b.alloc_i[0] = 1'b1; b.alloc_len_i[0] = 8'd10;
    b.retire_i[0] = 1'b1; b.retire_len_i[0] = 8'd2;
    tick();
    check("swap_accum", b.accum_o[0], 15);
    check("swap_out", b.outstanding_o[0], 1);
    check("swap_budget", b.budget_left_o[0], 15);
    do_clear();

    // Fill to MaxTxns, swap at full, then overflow
    for (int i = 0; i < 8; i++) begin
      b.alloc_i[0] = 1'b1;
      tick();
    end
    check("full_out", b.outstanding_o[0], 8);
    check("full_accum", b.accum_o[0], 40);
    b.alloc_i[0] = 1'b1; b.retire_i[0] = 1'b1;
    tick();
    check("full_swap_out", b.outstanding_o[0], 8);
    check("full_swap_ovf", b.err_overflow_o[0], 0);
    check("full_swap_udf", b.err_underflow_o[0], 0);
    b.alloc_i[0] = 1'b1;
    tick();
    check("ovf_flag", b.err_overflow_o[0], 1);
    check("ovf_out", b.outstanding_o[0], 8);
    check("ovf_accum", b.accum_o[0], 40);
    tick();
    check("ovf_sticky", b.err_overflow_o[0], 1);
    do_clear();

    // Underflow: retire on empty; on ch1 the simultaneous alloc still lands
    b.retire_i[0] = 1'b1; b.retire_len_i[0] = 8'd4;
    b.alloc_i[1] = 1'b1; b.alloc_len_i[1] = 8'd2;
    b.retire_i[1] = 1'b1; b.retire_len_i[1] = 8'd2;
    tick();
    check("udf_flag0", b.err_underflow_o[0], 1);
    check("udf_accum0", b.accum_o[0], 0);
    check("udf_out0", b.outstanding_o[0], 0);
    check("udf_flag1", b.err_underflow_o[1], 1);
    check("udf_accum1", b.accum_o[1], 7);
    check("udf_out1", b.outstanding_o[1], 1);
    do_clear();

    // CntWidth=8: saturation at 255, clamp at 0
    b8.alloc_i[0] = 1'b1; b8.alloc_len_i[0] = 8'd255;
    b8.alloc_i[1] = 1'b1; b8.alloc_len_i[1] = 8'd0;
    tick();
    check("sat_accum", b8.accum_o[0], 255);
    check("sat_ovf", b8.err_overflow_o[0], 1);
    check("sat_out", b8.outstanding_o[0], 1);
    check("pre_clamp_accum", b8.accum_o[1], 5);
    b8.retire_i[1] = 1'b1; b8.retire_len_i[1] = 8'd10;
    tick();
    check("clamp_accum", b8.accum_o[1], 0);
    check("clamp_udf", b8.err_underflow_o[1], 1);
    check("clamp_out", b8.outstanding_o[1], 0);
    do_clear();

    // Async reset mid-COUNT, inputs ignored while low, ch1 clean afterwards
    b.alloc_i[0] = 1'b1; b.alloc_len_i[0] = 8'd3;
    b.retire_i[1] = 1'b1;
    tick();
    check("pre_rst_budget", b.budget_left_o[0], 8);
    check("pre_rst_udf1", b.err_underflow_o[1], 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_accum", b.accum_o[0], 0);
    check("arst_out", b.outstanding_o[0], 0);
    check("arst_budget", b.budget_left_o[0], 0);
    check("arst_udf1", b.err_underflow_o[1], 0);
    b.alloc_i[0] = 1'b1; b.alloc_len_i[0] = 8'd3;
    @(posedge clk_i);
    #1;
    check("rst_ignore_out", b.outstanding_o[0], 0);
    idle_inputs();
    #2 rst_ni = 1'b1;
    b.alloc_i[1] = 1'b1; b.alloc_len_i[1] = 8'd4;
    tick();
    check("post_ch1_accum", b.accum_o[1], 9);
    check("post_ch1_out", b.outstanding_o[1], 1);
    check("post_ch1_budget", b.budget_left_o[1], 9);
    check("post_ch1_udf", b.err_underflow_o[1], 0);
    check("post_ch0_accum", b.accum_o[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
